// File: rtl/tag_arbiter_sa.sv
// tag_arbiter_sa: set-associative tag/valid/dirty tracker with invalid-first tree-PLRU
// victim choice and a write-back/refill miss sequencer toward the BIU.
module tag_arbiter_sa #(
    parameter int   SET_NUM      = 16,
    parameter int   SET_WID      = $clog2(SET_NUM),
    parameter int   WAY_NUM      = 4,
    parameter int   WAY_WID      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    parameter int   TAG_WID      = 14,
    parameter logic WBACK_ENABLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       entry_read,
    input  logic                       entry_wthru,
    input  logic                       entry_wback,
    input  logic [TAG_WID-1:0]         address_tag,
    input  logic [SET_WID-1:0]         address_set,
    input  logic                       valid_clear,
    input  logic                       line_refill,
    input  logic                       writeback_ok,
    output logic                       entry_hit,
    output logic [WAY_WID-1:0]         hit_way,
    output logic                       line_miss,
    output logic                       replace_dirty,
    output logic [TAG_WID-1:0]         victim_tag,
    output logic                       busy,
    output logic [SET_WID+WAY_WID-1:0] entry_select_addr
);
    localparam int LVL = $clog2(WAY_NUM);
    localparam int PL  = (WAY_NUM > 1) ? WAY_NUM - 1 : 1;

    typedef enum logic [1:0] {IDLE, WBACK, REFILL} state_t;

    logic [TAG_WID-1:0] r_tag_ram [SET_NUM][WAY_NUM];
    logic [WAY_NUM-1:0] r_valid [SET_NUM];
    logic [WAY_NUM-1:0] r_dirty [SET_NUM];
    logic [PL-1:0]      r_plru [SET_NUM];
    state_t             r_state;
    logic [SET_WID-1:0] r_set;
    logic [WAY_WID-1:0] r_way;
    logic [TAG_WID-1:0] r_ltag;
    logic [TAG_WID-1:0] r_vtag;

    logic               w_access;
    logic               w_idle;
    logic               w_hit_any;
    logic               w_has_inv;
    logic [WAY_WID-1:0] w_hit_way;
    logic [WAY_WID-1:0] w_inv_way;
    logic [WAY_WID-1:0] w_victim;
    int                 w_node;

    // Heap-ordered tree: bit 1 at a node means the victim lies in its right half.
    function automatic logic [PL-1:0] plru_upd(input logic [PL-1:0] p, input logic [WAY_WID-1:0] w);
        logic [PL-1:0] q;
        int n;
        q = p;
        n = 1;
        for (int l = 0; l < LVL; l++) begin
            q[n-1] = ~w[WAY_WID-1-l];
            n = 2 * n + int'(w[WAY_WID-1-l]);
        end
        return q;
    endfunction

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        w_node    = 1;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (r_valid[address_set][i] && r_tag_ram[address_set][i] == address_tag) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_WID'(i);
            end
            if (!r_valid[address_set][i]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_WID'(i);
            end
        end
        for (int l = 0; l < LVL; l++)
            w_node = 2 * w_node + int'(r_plru[address_set][w_node-1]);
    end

    assign w_victim          = w_has_inv ? w_inv_way : WAY_WID'(w_node - WAY_NUM);
    assign w_access          = entry_read | entry_wthru | entry_wback;
    assign w_idle            = r_state == IDLE;
    assign entry_hit         = w_idle & w_access & w_hit_any;
    assign hit_way           = entry_hit ? w_hit_way : '0;
    assign busy              = !w_idle;
    assign line_miss         = r_state == REFILL;
    assign replace_dirty     = r_state == WBACK;
    assign victim_tag        = r_vtag;
    assign entry_select_addr = !rst ? '0 : w_idle ? {address_set, hit_way} : {r_set, r_way};

    always_ff @(posedge clk)
        if (r_state == REFILL && line_refill)
            r_tag_ram[r_set][r_way] <= r_ltag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SET_NUM; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_state <= IDLE;
            r_set   <= '0;
            r_way   <= '0;
            r_ltag  <= '0;
            r_vtag  <= '0;
        end else begin
            case (r_state)
                IDLE:
                    if (valid_clear) begin
                        r_valid[address_set] <= '0;
                        r_dirty[address_set] <= '0;
                        r_plru[address_set]  <= '0;
                    end else if (w_access) begin
                        if (w_hit_any) begin
                            r_plru[address_set] <= plru_upd(r_plru[address_set], w_hit_way);
                            if (WBACK_ENABLE && entry_wback)
                                r_dirty[address_set][w_hit_way] <= 1'b1;
                        end else begin
                            r_set   <= address_set;
                            r_ltag  <= address_tag;
                            r_way   <= w_victim;
                            r_vtag  <= r_tag_ram[address_set][w_victim];
                            r_state <= (WBACK_ENABLE && r_valid[address_set][w_victim] &&
                                        r_dirty[address_set][w_victim]) ? WBACK : REFILL;
                        end
                    end
                WBACK:
                    if (writeback_ok) begin
                        r_dirty[r_set][r_way] <= 1'b0;
                        r_state               <= REFILL;
                    end
                REFILL:
                    if (line_refill) begin
                        r_valid[r_set][r_way] <= 1'b1;
                        r_dirty[r_set][r_way] <= 1'b0;
                        r_plru[r_set]         <= plru_upd(r_plru[r_set], r_way);
                        r_state               <= IDLE;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tag_arbiter_sa.sv
// tb_tag_arbiter_sa: scoreboard bench; a recency-based model predicts hits, victims and BIU requests.
module tb_tag_arbiter_sa;
    localparam int SN = 16, SW = 4, WN = 4, WW = 2, TW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rd, wt, wb, vclr, refill, wbok;
    logic [TW-1:0] tag;
    logic [SW-1:0] set;
    logic          hit, miss, rdirty, busy;
    logic [WW-1:0] hway;
    logic [TW-1:0] vtag;
    logic [SW+WW-1:0] sel;

    logic          t_rd, t_wb, t_refill;
    logic [TW-1:0] t_tag;
    logic [SW-1:0] t_set;
    logic          t_hit, t_hway, t_miss, t_rdirty, t_busy;
    logic [TW-1:0] t_vtag;
    logic [SW:0]   t_sel;

    tag_arbiter_sa u_dut (
        .clk(clk), .rst(rst), .entry_read(rd), .entry_wthru(wt), .entry_wback(wb),
        .address_tag(tag), .address_set(set), .valid_clear(vclr), .line_refill(refill),
        .writeback_ok(wbok), .entry_hit(hit), .hit_way(hway), .line_miss(miss),
        .replace_dirty(rdirty), .victim_tag(vtag), .busy(busy), .entry_select_addr(sel)
    );

    tag_arbiter_sa #(.WAY_NUM(1), .WBACK_ENABLE(1'b0)) u_wt (
        .clk(clk), .rst(rst), .entry_read(t_rd), .entry_wthru(1'b0), .entry_wback(t_wb),
        .address_tag(t_tag), .address_set(t_set), .valid_clear(1'b0), .line_refill(t_refill),
        .writeback_ok(1'b0), .entry_hit(t_hit), .hit_way(t_hway), .line_miss(t_miss),
        .replace_dirty(t_rdirty), .victim_tag(t_vtag), .busy(t_busy), .entry_select_addr(t_sel)
    );

    bit            m_v [SN][WN];
    bit            m_d [SN][WN];
    logic [TW-1:0] m_t [SN][WN];
    int            m_ts [SN][WN];
    int            stamp, checks, errors, vw, rs, rk;
    logic [TW-1:0] rt;

    typedef struct {bit hit; logic [WW-1:0] way; logic [SW+WW-1:0] sel;} acc_t;
    typedef struct {bit wbk; logic [SW+WW-1:0] sel; logic [TW-1:0] vt;} biu_t;
    acc_t acc_q[$];
    biu_t biu_q[$];
    acc_t a;
    biu_t b;
    logic p_miss, p_rd;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic push_acc(input bit h, input int w, input int s);
        acc_t e;
        e.hit = h;
        e.way = WW'(w);
        e.sel = {SW'(s), WW'(w)};
        acc_q.push_back(e);
    endtask

    task automatic push_biu(input bit k, input int s, input int w, input logic [TW-1:0] vt);
        biu_t e;
        e.wbk = k;
        e.sel = {SW'(s), WW'(w)};
        e.vt  = vt;
        biu_q.push_back(e);
    endtask

    task automatic touch(input int s, input int w);
        stamp++;
        m_ts[s][w] = stamp;
    endtask

    task automatic model_reset();
        for (int s = 0; s < SN; s++)
            for (int i = 0; i < WN; i++) begin
                m_v[s][i]  = 0;
                m_d[s][i]  = 0;
                m_ts[s][i] = 0;
            end
    endtask

    // Tree-PLRU as recency: at each split, evict from the half that does not hold the newest line.
    function automatic int victim(input int s);
        int lo, n, h, ml, mr;
        for (int i = 0; i < WN; i++)
            if (!m_v[s][i]) return i;
        lo = 0;
        n  = WN;
        while (n > 1) begin
            h  = n / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < h; i++) begin
                if (m_ts[s][lo+i] > ml) ml = m_ts[s][lo+i];
                if (m_ts[s][lo+h+i] > mr) mr = m_ts[s][lo+h+i];
            end
            if (ml > mr) lo += h;
            n = h;
        end
        return lo;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            p_miss = 0;
            p_rd   = 0;
        end else begin
            if ((rd | wt | wb) && !busy) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected: hit=%0b expected no access response", hit);
                end else begin
                    a = acc_q.pop_front();
                    chk("entry_hit", hit, a.hit);
                    chk("hit_way", hway, a.way);
                    chk("sel_idle", sel, a.sel);
                end
            end
            chk("miss_excl", miss & rdirty, 0);
            if ((miss && !p_miss) || (rdirty && !p_rd)) begin
                if (biu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL biu_unexpected: miss=%0b wback=%0b expected none", miss, rdirty);
                end else begin
                    b = biu_q.pop_front();
                    chk("biu_kind", rdirty, b.wbk);
                    chk("biu_sel", sel, b.sel);
                    if (b.wbk) chk("victim_tag", vtag, b.vt);
                end
            end
            p_miss = miss;
            p_rd   = rdirty;
        end
    end

    task automatic access(input int k, input int s, input logic [TW-1:0] t);
        int w, n;
        bit h, wbk;
        @(posedge clk); #1;
        rd = (k == 0); wt = (k == 1); wb = (k == 2); set = SW'(s); tag = t;
        h = 0;
        w = 0;
        for (int i = 0; i < WN; i++)
            if (m_v[s][i] && m_t[s][i] == t) begin h = 1; w = i; end
        if (h) begin
            push_acc(1, w, s);
            touch(s, w);
            if (k == 2) m_d[s][w] = 1;
        end else begin
            w   = victim(s);
            wbk = m_v[s][w] && m_d[s][w];
            push_acc(0, 0, s);
            if (wbk) push_biu(1, s, w, m_t[s][w]);
            push_biu(0, s, w, '0);
            @(posedge clk); #1;
            chk("busy_after_miss", busy, 1);
            set = SW'($urandom);
            tag = TW'($urandom);
            if (wbk) begin
                n = 0;
                while (!rdirty && n < 20) begin @(posedge clk); #1; n++; end
                chk("wback_seen", rdirty, 1);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                wbok = 1;
                @(posedge clk); #1;
                wbok = 0;
            end
            n = 0;
            while (!miss && n < 20) begin @(posedge clk); #1; n++; end
            chk("refill_seen", miss, 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            refill = 1;
            set = SW'(s);
            tag = t;
            @(posedge clk); #1;
            refill = 0;
            m_t[s][w] = t;
            m_v[s][w] = 1;
            m_d[s][w] = 0;
            touch(s, w);
            push_acc(1, w, s);
            touch(s, w);
            if (k == 2) m_d[s][w] = 1;
        end
        @(posedge clk); #1;
        rd = 0; wt = 0; wb = 0;
    endtask

    task automatic clr(input int s, input bit with_rd, input logic [TW-1:0] t);
        int w;
        bit h;
        @(posedge clk); #1;
        vclr = 1; set = SW'(s); tag = t; rd = with_rd;
        if (with_rd) begin
            h = 0;
            w = 0;
            for (int i = 0; i < WN; i++)
                if (m_v[s][i] && m_t[s][i] == t) begin h = 1; w = i; end
            push_acc(h, w, s);
        end
        @(posedge clk); #1;
        vclr = 0; rd = 0;
        for (int i = 0; i < WN; i++) begin
            m_v[s][i]  = 0;
            m_d[s][i]  = 0;
            m_ts[s][i] = 0;
        end
        chk("clr_no_miss", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0; rd = 0; wt = 0; wb = 0; vclr = 0; refill = 0; wbok = 0;
        t_rd = 0; t_wb = 0; t_refill = 0; t_tag = '0; t_set = 3;
        checks = 0; errors = 0; stamp = 0;
        set = 5; tag = 'h123;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rd = 1; t_rd = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_miss", miss, 0);
        chk("rst_wback", rdirty, 0);
        chk("rst_hit", hit, 0);
        chk("rst_sel", sel, 0);
        chk("rst_vtag", vtag, 0);
        chk("rst_wt_sel", t_sel, 0);
        rd = 0; t_rd = 0;
        @(posedge clk); #1 rst = 1;

        access(0, 3, 'h0A5);
        access(0, 3, 'h0A5);

        for (int i = 0; i < 4; i++) access(0, 5, TW'('h10 + i));
        access(0, 5, 'h10);
        access(0, 5, 'h12);
        access(0, 5, 'h20);

        access(0, 2, 'h1);
        access(0, 2, 'h7);
        access(2, 2, 'h7);
        access(0, 2, 'h1);
        access(1, 2, 'h8);
        access(0, 2, 'h9);
        access(0, 2, 'h30);
        access(0, 2, 'h30);

        for (int i = 0; i < 4; i++) access(0, 7, TW'('h40 + i));
        clr(7, 1, 'h41);
        access(0, 7, 'h50);

        @(posedge clk); #1;
        t_set = 1; t_tag = 'h11; t_rd = 1;
        #1 chk("wt_first_miss", t_hit, 0);
        @(posedge clk); #1;
        chk("wt_refill_req", t_miss, 1);
        chk("wt_sel", t_sel, {4'd1, 1'b0});
        t_refill = 1;
        @(posedge clk); #1;
        t_refill = 0;
        chk("wt_retry_hit", t_hit, 1);
        t_rd = 0; t_wb = 1;
        #1 chk("wt_wb_hit", t_hit, 1);
        @(posedge clk); #1;
        t_tag = 'h22;
        #1 chk("wt_evict_miss", t_hit, 0);
        @(posedge clk); #1;
        chk("wt_no_wback", t_rdirty, 0);
        chk("wt_direct_refill", t_miss, 1);
        t_refill = 1;
        @(posedge clk); #1;
        t_refill = 0;
        chk("wt_new_hit", t_hit, 1);
        chk("wt_idle", t_busy, 0);
        @(posedge clk); #1;
        t_wb = 0;

        @(posedge clk); #1;
        rd = 1; set = 9; tag = 'h155;
        vw = victim(9);
        push_acc(0, 0, 9);
        push_biu(0, 9, vw, '0);
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        @(negedge clk); #2;
        rst = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_miss", miss, 0);
        chk("abort_sel", sel, 0);
        chk("abort_hit", hit, 0);
        chk("abort_queues", acc_q.size() + biu_q.size(), 0);
        model_reset();
        rd = 0;
        @(posedge clk); #1;
        rst = 1; refill = 1;
        @(posedge clk); #1;
        refill = 0;
        chk("stray_refill_busy", busy, 0);
        chk("stray_refill_miss", miss, 0);
        access(0, 9, 'h155);
        access(0, 9, 'h155);

        for (int i = 0; i < 250; i++) begin
            rs = $urandom_range(0, 3);
            rt = TW'($urandom_range(0, 7));
            rk = $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) clr(rs, 1'($urandom_range(0, 1)), rt);
            else access(rk, rs, rt);
        end

        repeat (3) @(posedge clk);
        #1 chk("queues_drained", acc_q.size() + biu_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
